// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte requesters, the arbiter and the shared UART transmitter.
// The arbiter takes the slave view; whoever drives requests and the transmitter's done pulse takes the master view.
interface uart_tx_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DBITS = 8
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DBITS-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  tx_start;
    logic [DBITS-1:0]      tx_din;
    logic                  tx_done_tick;
    logic                  busy;
    logic [IDW-1:0]        grant_id;
    logic                  err_timeout;

    modport slave (
        input  req_valid, req_data, tx_done_tick,
        output req_ready, tx_start, tx_din, busy, grant_id, err_timeout
    );

    modport master (
        output req_valid, req_data, tx_done_tick,
        input  req_ready, tx_start, tx_din, busy, grant_id, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte sources.
// Each grant may continue as a burst of up to MAX_BURST bytes from the same source;
// a watchdog abandons a frame whose done pulse never arrives.
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int DBITS     = 8,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 200000
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW  = $clog2(MAX_BURST + 1);
    localparam int WW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [IDW-1:0]   last_reg;
    logic [IDW-1:0]   grant_reg;
    logic [BW-1:0]    burst_cnt_reg;
    logic [WW-1:0]    wd_cnt_reg;
    logic             tx_start_reg;
    logic [DBITS-1:0] tx_din_reg;
    logic             err_reg;

    logic [DBITS-1:0] data_arr [NREQ];
    logic             pick_found;
    logic [IDW-1:0]   pick_idx;
    logic             burst_more;
    logic [NREQ-1:0]  ready_next;

    // Unpack the flat data bus into one lane per requester.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
        assign data_arr[gi] = bus.req_data[gi*DBITS +: DBITS];
    end

    // Round-robin pick: lowest valid index above the last grant, else lowest valid index at or below it.
    always_comb begin
        logic           found_hi;
        logic           found_lo;
        logic [IDW-1:0] idx_hi;
        logic [IDW-1:0] idx_lo;
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                if (IDW'(i) > last_reg) begin
                    found_hi = 1'b1;
                    idx_hi   = IDW'(i);
                end else begin
                    found_lo = 1'b1;
                    idx_lo   = IDW'(i);
                end
            end
        end
        pick_found = found_hi | found_lo;
        pick_idx   = found_hi ? idx_hi : idx_lo;
    end

    assign burst_more = (burst_cnt_reg < BW'(MAX_BURST - 1)) && bus.req_valid[grant_reg];

    // Accept strobe: a new grant in IDLE, or a burst continuation on the done pulse in WAIT.
    always_comb begin
        ready_next = '0;
        if (!reset) begin
            case (state_reg)
                S_IDLE: if (pick_found) ready_next = NREQ'(1) << pick_idx;
                S_WAIT: if (bus.tx_done_tick && burst_more) ready_next = NREQ'(1) << grant_reg;
                default: ready_next = '0;
            endcase
        end
    end

    // Grant/issue/wait sequencer with registered transmitter-facing outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            last_reg      <= IDW'(NREQ - 1);
            grant_reg     <= '0;
            burst_cnt_reg <= '0;
            wd_cnt_reg    <= '0;
            tx_start_reg  <= 1'b0;
            tx_din_reg    <= '0;
            err_reg       <= 1'b0;
        end else begin
            tx_start_reg <= 1'b0;
            err_reg      <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (pick_found) begin
                        tx_din_reg    <= data_arr[pick_idx];
                        grant_reg     <= pick_idx;
                        burst_cnt_reg <= '0;
                        tx_start_reg  <= 1'b1;
                        state_reg     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wd_cnt_reg <= '0;
                    state_reg  <= S_WAIT;
                end
                S_WAIT: begin
                    wd_cnt_reg <= wd_cnt_reg + WW'(1);
                    // A done pulse always wins over a coincident watchdog expiry.
                    if (bus.tx_done_tick) begin
                        if (burst_more) begin
                            tx_din_reg    <= data_arr[grant_reg];
                            burst_cnt_reg <= burst_cnt_reg + BW'(1);
                            tx_start_reg  <= 1'b1;
                            state_reg     <= S_ISSUE;
                        end else begin
                            last_reg  <= grant_reg;
                            state_reg <= S_IDLE;
                        end
                    end else if (wd_cnt_reg == WW'(TIMEOUT - 1)) begin
                        err_reg   <= 1'b1;
                        last_reg  <= grant_reg;
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = ready_next;
    assign bus.tx_start    = tx_start_reg;
    assign bus.tx_din      = tx_din_reg;
    assign bus.busy        = (state_reg != S_IDLE);
    assign bus.grant_id    = grant_reg;
    assign bus.err_timeout = err_reg;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance with single-byte grants, one with bursts of four.
module tb_uart_tx_arbiter;
    localparam int NREQ  = 4;
    localparam int DBITS = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   g;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ), .DBITS(DBITS)) bus1 ();
    uart_tx_arbiter_if #(.NREQ(NREQ), .DBITS(DBITS)) bus4 ();

    uart_tx_arbiter #(.NREQ(NREQ), .DBITS(DBITS), .MAX_BURST(1), .TIMEOUT(50)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    uart_tx_arbiter #(.NREQ(NREQ), .DBITS(DBITS), .MAX_BURST(4), .TIMEOUT(50)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus1.req_valid = '0; bus1.req_data = '0; bus1.tx_done_tick = 1'b0;
        bus4.req_valid = '0; bus4.req_data = '0; bus4.tx_done_tick = 1'b0;

        // Reset state; req_ready held low by reset even with every request pending
        reset = 1'b1;
        bus1.req_valid = 4'b1111;
        bus4.req_valid = 4'b1111;
        tick(); tick(); #1;
        chk("rst_ready1", 32'(bus1.req_ready), 32'h0);
        chk("rst_ready4", 32'(bus4.req_ready), 32'h0);
        chk("rst_busy", 32'(bus1.busy), 32'h0);
        chk("rst_tx_start", 32'(bus1.tx_start), 32'h0);
        chk("rst_tx_din", 32'(bus1.tx_din), 32'h0);
        chk("rst_grant", 32'(bus1.grant_id), 32'h0);
        chk("rst_err", 32'(bus1.err_timeout), 32'h0);
        bus1.req_valid = '0;
        bus4.req_valid = '0;
        reset = 1'b0;
        tick();
        $display("step reset: busy=%0d tx_start=%0d", bus1.busy, bus1.tx_start);

        // Single byte A5 from requester 0
        bus1.req_valid = 4'b0001;
        bus1.req_data[7:0] = 8'hA5;
        #1;
        chk("t1_ready", 32'(bus1.req_ready), 32'h1);
        tick();
        bus1.req_valid = '0;
        chk("t1_start", 32'(bus1.tx_start), 32'h1);
        chk("t1_din", 32'(bus1.tx_din), 32'hA5);
        chk("t1_grant", 32'(bus1.grant_id), 32'h0);
        tick();
        chk("t1_start_low", 32'(bus1.tx_start), 32'h0);
        chk("t1_busy", 32'(bus1.busy), 32'h1);
        tick(); tick();
        chk("t1_din_hold", 32'(bus1.tx_din), 32'hA5);
        bus1.tx_done_tick = 1'b1;
        tick();
        bus1.tx_done_tick = 1'b0;
        chk("t1_idle", 32'(bus1.busy), 32'h0);
        $display("step single: tx_din=%0h busy=%0d", bus1.tx_din, bus1.busy);

        // Round robin with all four valid and single-byte grants
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t2_rst_grant", 32'(bus1.grant_id), 32'h0);
        chk("t2_rst_din", 32'(bus1.tx_din), 32'h0);
        bus1.req_data = 32'h44332211;
        bus1.req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            g = n % 4;
            #1;
            chk("t2_ready", 32'(bus1.req_ready), 32'(1 << g));
            tick();
            chk("t2_start", 32'(bus1.tx_start), 32'h1);
            chk("t2_grant", 32'(bus1.grant_id), 32'(g));
            chk("t2_din", 32'(bus1.tx_din), 32'(8'h11 * (g + 1)));
            tick();
            chk("t2_start_low", 32'(bus1.tx_start), 32'h0);
            tick();
            bus1.tx_done_tick = 1'b1;
            #1;
            chk("t2_no_burst", 32'(bus1.req_ready), 32'h0);
            tick();
            bus1.tx_done_tick = 1'b0;
            chk("t2_idle", 32'(bus1.busy), 32'h0);
            $display("step rr: grant=%0d tx_din=%0h", bus1.grant_id, bus1.tx_din);
        end
        bus1.req_valid = '0;

        // Watchdog: requester 2 granted, transmitter never reports done
        bus1.req_data[23:16] = 8'h5C;
        bus1.req_valid = 4'b0100;
        #1;
        chk("t3_ready", 32'(bus1.req_ready), 32'h4);
        tick();
        bus1.req_valid = '0;
        chk("t3_start", 32'(bus1.tx_start), 32'h1);
        chk("t3_grant", 32'(bus1.grant_id), 32'h2);
        tick();
        for (int k = 1; k <= 49; k++) tick();
        chk("t3_busy_before", 32'(bus1.busy), 32'h1);
        chk("t3_err_before", 32'(bus1.err_timeout), 32'h0);
        tick();
        chk("t3_err", 32'(bus1.err_timeout), 32'h1);
        chk("t3_idle", 32'(bus1.busy), 32'h0);
        bus1.req_valid = 4'b0101;
        #1;
        chk("t3_ptr", 32'(bus1.req_ready), 32'h1);
        tick();
        bus1.req_valid = '0;
        chk("t3_err_pulse", 32'(bus1.err_timeout), 32'h0);
        chk("t3_next_grant", 32'(bus1.grant_id), 32'h0);
        $display("step timeout: grant=%0d", bus1.grant_id);

        // Done coincident with the last watchdog cycle: normal completion
        tick();
        for (int k = 1; k <= 49; k++) tick();
        bus1.tx_done_tick = 1'b1;
        tick();
        bus1.tx_done_tick = 1'b0;
        chk("t4_no_err", 32'(bus1.err_timeout), 32'h0);
        chk("t4_idle", 32'(bus1.busy), 32'h0);
        $display("step done_vs_timeout: err=%0d busy=%0d", bus1.err_timeout, bus1.busy);

        // Reset while waiting on requester 3
        bus1.req_valid = 4'b1000;
        #1;
        chk("t5_ready", 32'(bus1.req_ready), 32'h8);
        tick();
        chk("t5_grant", 32'(bus1.grant_id), 32'h3);
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("t5_busy", 32'(bus1.busy), 32'h0);
        chk("t5_start", 32'(bus1.tx_start), 32'h0);
        chk("t5_grant_rst", 32'(bus1.grant_id), 32'h0);
        reset = 1'b0;
        bus1.req_valid = 4'b1001;
        #1;
        chk("t5_first", 32'(bus1.req_ready), 32'h1);
        tick();
        bus1.req_valid = '0;
        chk("t5_start_after", 32'(bus1.tx_start), 32'h1);
        chk("t5_grant_after", 32'(bus1.grant_id), 32'h0);
        $display("step reset_wait: grant=%0d", bus1.grant_id);

        // Burst of four from requester 2, then requester 1, then 2 resumes
        bus4.req_data[23:16] = 8'hB0;
        bus4.req_data[15:8] = 8'hC1;
        bus4.req_valid = 4'b0100;
        #1;
        chk("t6_ready", 32'(bus4.req_ready), 32'h4);
        tick();
        bus4.req_valid = 4'b0110;
        chk("t6_start", 32'(bus4.tx_start), 32'h1);
        chk("t6_din0", 32'(bus4.tx_din), 32'hB0);
        for (int b = 1; b < 4; b++) begin
            bus4.req_data[23:16] = 8'(8'hB0 + b);
            tick();
            bus4.tx_done_tick = 1'b1;
            #1;
            chk("t6_burst_ready", 32'(bus4.req_ready), 32'h4);
            tick();
            bus4.tx_done_tick = 1'b0;
            chk("t6_burst_start", 32'(bus4.tx_start), 32'h1);
            chk("t6_burst_din", 32'(bus4.tx_din), 32'(8'hB0 + b));
            chk("t6_burst_grant", 32'(bus4.grant_id), 32'h2);
            $display("step burst: grant=%0d tx_din=%0h", bus4.grant_id, bus4.tx_din);
        end
        bus4.req_data[23:16] = 8'hB4;
        tick();
        bus4.tx_done_tick = 1'b1;
        #1;
        chk("t6_burst_end", 32'(bus4.req_ready), 32'h0);
        tick();
        bus4.tx_done_tick = 1'b0;
        chk("t6_idle", 32'(bus4.busy), 32'h0);
        #1;
        chk("t6_other", 32'(bus4.req_ready), 32'h2);
        tick();
        bus4.req_valid = 4'b0100;
        chk("t6_other_din", 32'(bus4.tx_din), 32'hC1);
        chk("t6_other_grant", 32'(bus4.grant_id), 32'h1);
        tick();
        bus4.tx_done_tick = 1'b1;
        #1;
        chk("t6_drop_ends", 32'(bus4.req_ready), 32'h0);
        tick();
        bus4.tx_done_tick = 1'b0;
        #1;
        chk("t6_resume", 32'(bus4.req_ready), 32'h4);
        tick();
        bus4.req_valid = '0;
        chk("t6_resume_din", 32'(bus4.tx_din), 32'hB4);
        chk("t6_resume_grant", 32'(bus4.grant_id), 32'h2);
        $display("step resume: grant=%0d tx_din=%0h", bus4.grant_id, bus4.tx_din);
        tick();
        bus4.tx_done_tick = 1'b1;
        tick();
        bus4.tx_done_tick = 1'b0;
        chk("t6_final_idle", 32'(bus4.busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
